// File: rtl/lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Load/store alignment unit. It turns byte/halfword/word CPU
//             accesses into word-aligned full-word RAM reads and writes.
//             Loads are lane-extracted and sign/zero extended. Sub-word
//             stores use read-modify-write. Illegal or misaligned requests
//             are answered with an error and never touch memory.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  func3_q, func3_d;
    logic        write_q, write_d;
    logic [31:0] wbuf_q,  wbuf_d;
    logic        err_q,   err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_f3_legal;
    logic        w_misaligned;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    // Legality and alignment of the request presented on the input port
    always_comb begin
        w_f3_legal   = 1'b0;
        w_misaligned = 1'b0;
        case (req_func3)
            C_F3_B:  w_f3_legal = 1'b1;
            C_F3_H:  begin w_f3_legal = 1'b1; w_misaligned = req_addr[0]; end
            C_F3_W:  begin w_f3_legal = 1'b1; w_misaligned = (req_addr[1:0] != 2'b00); end
            C_F3_BU: w_f3_legal = !req_write;
            C_F3_HU: begin w_f3_legal = !req_write; w_misaligned = req_addr[0]; end
            default: w_f3_legal = 1'b0;
        endcase
        w_req_err = !w_f3_legal || w_misaligned;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        w_byte     = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        w_half     = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        w_load_val = mem_rdata;
        case (func3_q)
            C_F3_B:  w_load_val = {{24{w_byte[7]}}, w_byte};
            C_F3_BU: w_load_val = {24'd0, w_byte};
            C_F3_H:  w_load_val = {{16{w_half[15]}}, w_half};
            C_F3_HU: w_load_val = {16'd0, w_half};
            default: w_load_val = mem_rdata;
        endcase
        w_merged = mem_rdata;
        if (func3_q == C_F3_B) begin
            w_merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
        end else if (func3_q == C_F3_H) begin
            w_merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
        end
    end

    // Next-state and datapath update for the access sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        write_d = write_q;
        wbuf_d  = wbuf_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    func3_d = req_func3;
                    write_d = req_write;
                    if (w_req_err) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else if (req_write) begin
                        wbuf_d  = req_wdata;
                        state_d = (req_func3 == C_F3_W) ? S_WR_ISSUE : S_RD_ISSUE;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (write_q) begin
                    wbuf_d  = w_merged;
                    state_d = S_WR_ISSUE;
                end else begin
                    err_d   = 1'b0;
                    rdata_d = w_load_val;
                    state_d = S_RESP;
                end
            end
            S_WR_ISSUE: begin
                err_d   = 1'b0;
                rdata_d = 32'd0;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request, write buffer and response registers
    always_ff @(posedge clk) begin
        if (clr) begin
            addr_q  <= 32'd0;
            func3_q <= 3'd0;
            write_q <= 1'b0;
            wbuf_q  <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            addr_q  <= addr_d;
            func3_q <= func3_d;
            write_q <= write_d;
            wbuf_q  <= wbuf_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes are gated by clr so a reset during an issue cycle cancels it
    assign req_ready  = (state_q == S_IDLE)     && !clr;
    assign mem_read   = (state_q == S_RD_ISSUE) && !clr;
    assign mem_write  = (state_q == S_WR_ISSUE) && !clr;
    assign resp_valid = (state_q == S_RESP)     && !clr;
    assign mem_addr   = (state_q != S_IDLE) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = wbuf_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_align
//  Purpose  : Self-checking bench for lsu_align with a word RAM model and a
//             behavioural reference for load/store/error results and timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    lsu_align dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM: registered read, write committed at the edge
    logic [31:0] ram [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'd0;
    logic [31:0] poke_data = 32'd0;

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_data;
        else if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
        if (mem_read) mem_rdata <= ram[mem_addr[9:2]];
    end

    // ---------------- reference model ----------------
    function automatic bit m_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int sz;
        legal = w ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                  : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz = 1 << f3[1:0];
        return !legal || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256; end
            3'd4: v = sh & 32'hFF;
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd5: v = sh & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] mask;
        int off;
        off  = 8 * (a % 4);
        mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << off;
        return (old & ~mask) | ((wd << off) & mask);
    endfunction

    // ---------------- stimulus / observation ----------------
    int          ob_rd_n, ob_wr_n, ob_rd_cyc, ob_wr_cyc, ob_resp_cyc;
    logic [31:0] ob_rd_addr, ob_wr_addr, ob_wr_data, ob_rdata;
    logic        ob_err, ob_overlap, ob_ready0, ob_ready_early, ob_ready_after;

    task automatic poke(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        poke_idx  = idx;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request and record what the unit does in the following cycles
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        ob_ready0 = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ob_rd_n = 0; ob_wr_n = 0; ob_rd_cyc = 0; ob_wr_cyc = 0; ob_resp_cyc = 0;
        ob_rd_addr = '0; ob_wr_addr = '0; ob_wr_data = '0; ob_rdata = '0; ob_err = 1'b0;
        ob_overlap = 1'b0; ob_ready_early = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read)  begin ob_rd_n++; ob_rd_cyc = c; ob_rd_addr = mem_addr; end
            if (mem_write) begin ob_wr_n++; ob_wr_cyc = c; ob_wr_addr = mem_addr; ob_wr_data = mem_wdata; end
            if (mem_read && mem_write) ob_overlap = 1'b1;
            if (req_ready) ob_ready_early = 1'b1;
            if (resp_valid) begin ob_resp_cyc = c; ob_rdata = resp_rdata; ob_err = resp_err; break; end
        end
        @(negedge clk);
        ob_ready_after = req_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        clr = 1'b1; req_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, mem_read, mem_write, resp_valid} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_strobes: got %b want 0000", {req_ready, mem_read, mem_write, resp_valid});
        end
        clr = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++;
        if ({resp_err, resp_rdata, mem_addr, mem_wdata} !== 97'd0) begin
            n_errors++; $display("FAIL reset_regs: err=%b rdata=%h addr=%h wdata=%h want all 0", resp_err, resp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_lw;
        poke(8'h40, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h100, 32'd0);
        n_checks++;
        if (ob_rd_cyc !== 1 || ob_rd_n !== 1) begin n_errors++; $display("FAIL lw_read: cyc=%0d n=%0d want cyc 1 n 1", ob_rd_cyc, ob_rd_n); end
        n_checks++;
        if (ob_rd_addr !== 32'h100) begin n_errors++; $display("FAIL lw_addr: got %h want 00000100", ob_rd_addr); end
        n_checks++;
        if (ob_resp_cyc !== 3) begin n_errors++; $display("FAIL lw_resp_cyc: got %0d want 3", ob_resp_cyc); end
        n_checks++;
        if (ob_rdata !== 32'hDEADBEEF || ob_err !== 1'b0) begin
            n_errors++; $display("FAIL lw_data: got %h err %b want deadbeef err 0", ob_rdata, ob_err);
        end
    endtask

    task automatic test_sub_loads;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h00007F01};
        poke(8'h40, 32'h80F07F01);
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, f3s[i], adrs[i], 32'd0);
            n_checks++;
            if (ob_resp_cyc !== 3 || ob_rdata !== exps[i] || ob_err !== 1'b0) begin
                n_errors++; $display("FAIL subload_%0d: cyc=%0d rdata=%h err=%b want cyc 3 rdata %h err 0", i, ob_resp_cyc, ob_rdata, ob_err, exps[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic        ws   [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s  [3] = '{3'b010, 3'b001, 3'b100};
        logic [31:0] adrs [3] = '{32'h102, 32'h101, 32'h100};
        poke(8'h40, 32'h5555AAAA);
        for (int i = 0; i < 3; i++) begin
            run_req(ws[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
            n_checks++;
            if (ob_resp_cyc !== 1 || ob_err !== 1'b1 || ob_rdata !== 32'd0) begin
                n_errors++; $display("FAIL err_%0d: cyc=%0d err=%b rdata=%h want cyc 1 err 1 rdata 0", i, ob_resp_cyc, ob_err, ob_rdata);
            end
            n_checks++;
            if (ob_rd_n !== 0 || ob_wr_n !== 0 || ram[8'h40] !== 32'h5555AAAA) begin
                n_errors++; $display("FAIL err_mem_%0d: reads=%0d writes=%0d ram=%h want 0 0 5555aaaa", i, ob_rd_n, ob_wr_n, ram[8'h40]);
            end
        end
    endtask

    task automatic test_sub_stores;
        logic [2:0]  f3s  [2] = '{3'b000, 3'b001};
        logic [31:0] adrs [2] = '{32'h101, 32'h102};
        logic [31:0] wds  [2] = '{32'h000000AB, 32'h0000CAFE};
        logic [31:0] exps [2] = '{32'h1122AB44, 32'hCAFE3344};
        for (int i = 0; i < 2; i++) begin
            poke(8'h40, 32'h11223344);
            run_req(1'b1, f3s[i], adrs[i], wds[i]);
            n_checks++;
            if (ob_rd_cyc !== 1 || ob_wr_cyc !== 3 || ob_resp_cyc !== 4) begin
                n_errors++; $display("FAIL substore_timing_%0d: rd=%0d wr=%0d resp=%0d want 1 3 4", i, ob_rd_cyc, ob_wr_cyc, ob_resp_cyc);
            end
            n_checks++;
            if (ob_wr_data !== exps[i] || ram[8'h40] !== exps[i]) begin
                n_errors++; $display("FAIL substore_data_%0d: wdata=%h ram=%h want %h", i, ob_wr_data, ram[8'h40], exps[i]);
            end
            n_checks++;
            if (ob_rdata !== 32'd0 || ob_err !== 1'b0) begin
                n_errors++; $display("FAIL substore_resp_%0d: rdata=%h err=%b want 0 0", i, ob_rdata, ob_err);
            end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 60; it++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a, wd, old, e_rdata, e_ram, e_wdata;
            int          e_rd, e_wr, e_resp;
            bit          e_err;
            w   = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = 32'($urandom_range(0, 1023));
            wd  = $urandom;
            old = $urandom;
            poke(a[9:2], old);
            e_err = m_err(w, f3, a);
            e_rdata = 32'd0; e_ram = old; e_wdata = 32'd0; e_rd = 0; e_wr = 0;
            if (e_err) begin
                e_resp = 1;
            end else if (!w) begin
                e_rd = 1; e_resp = 3; e_rdata = m_load(f3, a, old);
            end else if (f3 == 3'd2) begin
                e_wr = 1; e_resp = 2; e_ram = wd; e_wdata = wd;
            end else begin
                e_rd = 1; e_wr = 3; e_resp = 4; e_ram = m_store(f3, a, old, wd); e_wdata = e_ram;
            end
            run_req(w, f3, a, wd);
            n_checks++;
            if (ob_ready0 !== 1'b1 || ob_ready_early !== 1'b0 || ob_ready_after !== 1'b1) begin
                n_errors++; $display("FAIL rnd_ready_%0d: before=%b busy=%b after=%b want 1 0 1", it, ob_ready0, ob_ready_early, ob_ready_after);
            end
            n_checks++;
            if (ob_resp_cyc !== e_resp || ob_err !== e_err || ob_rdata !== e_rdata) begin
                n_errors++; $display("FAIL rnd_resp_%0d: w=%b f3=%0d a=%h cyc=%0d err=%b rdata=%h want cyc %0d err %b rdata %h",
                                     it, w, f3, a, ob_resp_cyc, ob_err, ob_rdata, e_resp, e_err, e_rdata);
            end
            n_checks++;
            if (ob_rd_cyc !== e_rd || ob_wr_cyc !== e_wr || ob_rd_n !== (e_rd != 0 ? 1 : 0) ||
                ob_wr_n !== (e_wr != 0 ? 1 : 0) || ob_overlap !== 1'b0) begin
                n_errors++; $display("FAIL rnd_strobes_%0d: rd=%0d/%0d wr=%0d/%0d overlap=%b want rd %0d wr %0d",
                                     it, ob_rd_cyc, ob_rd_n, ob_wr_cyc, ob_wr_n, ob_overlap, e_rd, e_wr);
            end
            if (e_rd != 0) begin
                n_checks++;
                if (ob_rd_addr !== {a[31:2], 2'b00}) begin
                    n_errors++; $display("FAIL rnd_rdaddr_%0d: got %h want %h", it, ob_rd_addr, {a[31:2], 2'b00});
                end
            end
            if (e_wr != 0) begin
                n_checks++;
                if (ob_wr_addr !== {a[31:2], 2'b00} || ob_wr_data !== e_wdata) begin
                    n_errors++; $display("FAIL rnd_wr_%0d: addr=%h data=%h want %h %h", it, ob_wr_addr, ob_wr_data, {a[31:2], 2'b00}, e_wdata);
                end
            end
            n_checks++;
            if (ram[a[9:2]] !== e_ram) begin
                n_errors++; $display("FAIL rnd_ram_%0d: got %h want %h", it, ram[a[9:2]], e_ram);
            end
        end
    endtask

    task automatic test_reset_in_wr;
        bit saw_bad;
        poke(8'h40, 32'h11223344);
        run_req(1'b0, 3'b010, 32'h100, 32'd0);
        @(negedge clk);
        req_write = 1'b1; req_func3 = 3'b000; req_addr = 32'h101; req_wdata = 32'hAB; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b1) begin n_errors++; $display("FAIL rst_wr_pre: mem_write=%b want 1", mem_write); end
        clr = 1'b1;
        #1;
        n_checks++;
        if ({mem_write, resp_valid, req_ready} !== 3'b000) begin
            n_errors++; $display("FAIL rst_wr_gate: write/resp/ready=%b want 000", {mem_write, resp_valid, req_ready});
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || mem_wdata !== 32'd0) begin
            n_errors++; $display("FAIL rst_wr_after: ready=%b rdata=%h err=%b wdata=%h want 1 0 0 0", req_ready, resp_rdata, resp_err, mem_wdata);
        end
        saw_bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_write || resp_valid || mem_read) saw_bad = 1'b1;
        end
        n_checks++;
        if (saw_bad !== 1'b0 || ram[8'h40] !== 32'h11223344) begin
            n_errors++; $display("FAIL rst_wr_quiet: activity=%b ram=%h want 0 11223344", saw_bad, ram[8'h40]);
        end
    endtask

    task automatic test_back_to_back;
        int acc_n, resp_n, rd_n, first_resp;
        int acc_cyc [3];
        bit overlap;
        logic [31:0] rdat;
        poke(8'h40, 32'hDEADBEEF);
        acc_n = 0; resp_n = 0; rd_n = 0; overlap = 1'b0; rdat = '0; first_resp = -1;
        acc_cyc = '{-1, -1, -1};
        @(negedge clk);
        req_write = 1'b0; req_func3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            if (req_valid && req_ready) begin
                if (acc_n < 3) acc_cyc[acc_n] = k;
                acc_n++;
            end
            if (resp_valid) begin resp_n++; rdat = resp_rdata; if (first_resp < 0) first_resp = k; end
            if (mem_read) rd_n++;
            if (mem_read && mem_write) overlap = 1'b1;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        n_checks++;
        if (acc_n !== 3 || acc_cyc[0] !== 0 || acc_cyc[1] !== 4 || acc_cyc[2] !== 8) begin
            n_errors++; $display("FAIL b2b_accept: n=%0d at %0d,%0d,%0d want 3 at 0,4,8", acc_n, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_checks++;
        if (resp_n !== 2 || first_resp !== 3 || rd_n !== 2 || overlap !== 1'b0) begin
            n_errors++; $display("FAIL b2b_flow: resp=%0d first=%0d reads=%0d overlap=%b want 2 3 2 0", resp_n, first_resp, rd_n, overlap);
        end
        n_checks++;
        if (rdat !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_data: got %h want deadbeef", rdat); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_sub_loads;
        test_errors;
        test_sub_stores;
        test_random;
        test_reset_in_wr;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
